// File: rtl/vga_text_pixel_pipe.sv
// -----------------------------------------------------------------------------
// vga_text_pixel_pipe
//
// Text-mode render pipeline sitting between the VGA timing generator and the
// VGA pins. Every pixel strobe walks one screen position through three stages:
//
//   stage 1 : draw_x/draw_y -> character index -> VRAM word address
//   stage 2 : VRAM word     -> character code/inverse -> font ROM address
//   stage 3 : glyph row     -> pixel bit -> registered 4:4:4 RGB
//
// hs/vs travel alongside the pixel so they change together with RGB. The
// block also owns the frame_toggle status bit polled by software.
//
// Parameters
//   COLS          characters per row
//   ROWS          character rows (16 scanlines each)
//   BLINK_FRAMES  frames per cursor blink phase (cursor build only)
//
// Build option
//   VGA_TEXT_CURSOR_EN  when defined, adds a blinking underline cursor at
//                       cursor_pos (bottom two scanlines of the cell). When
//                       undefined, cursor_pos is ignored and no blink state
//                       exists.
//
// Ports
//   CLK           system clock, also the VRAM / font ROM clock
//   RESET         asynchronous reset, active-high
//   pixel_en      one-CLK pixel strobe, never high on two consecutive CLKs
//   draw_x/draw_y current pixel position from the timing generator
//   blank_n       1 = visible region
//   hs_in/vs_in   raw syncs, active-low
//   ctrl_reg      [24:13] foreground RGB, [12:1] background RGB
//   cursor_pos    character index of the cursor (row*COLS+col)
//   vram_addr     VRAM word address, data returns on vram_rdata 1 CLK later
//   vram_rdata    VRAM word, 4 characters, byte b = {IV, CODE[6:0]}
//   font_addr     {CODE, scanline}, data returns on font_data 1 CLK later
//   font_data     glyph row, bit 7 = leftmost pixel
//   red/green/blue registered pixel colour
//   hs/vs         syncs aligned with RGB
//   frame_toggle  flips once per frame (on each sampled vs falling edge)
// -----------------------------------------------------------------------------
module vga_text_pixel_pipe #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        pixel_en,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        blank_n,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [31:0] ctrl_reg,
  input  logic [11:0] cursor_pos,
  output logic [9:0]  vram_addr,
  input  logic [31:0] vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hs,
  output logic        vs,
  output logic        frame_toggle
);

  // Final colour selection. Blanking forces black; visible pixels outside the
  // text area show the background colour.
  function automatic logic [11:0] pick_rgb(input logic        visible,
                                           input logic        in_text,
                                           input logic        pix,
                                           input logic [11:0] fgd,
                                           input logic [11:0] bkg);
    logic [11:0] rgb;
    if (!visible) begin
      rgb = 12'h000;
    end else if (!in_text) begin
      rgb = bkg;
    end else begin
      rgb = pix ? fgd : bkg;
    end
    return rgb;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // control / output state (asynchronously reset)
  logic [9:0]  vram_addr_q;
  logic [10:0] font_addr_q;
  logic [11:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        frame_toggle_q;
  logic        vs_prev_q;
  logic        vld_p1_q;
  logic        vld_p2_q;

  // datapath state (no reset, qualified by the valid bits)
  logic [1:0]  byte_sel_p1_q;
  logic [3:0]  scan_p1_q;
  logic [2:0]  xbit_p1_q;
  logic        in_range_p1_q;
  logic        blank_n_p1_q;
  logic        hs_p1_q;
  logic        vs_p1_q;

  logic        inv_p2_q;
  logic [2:0]  xbit_p2_q;
  logic        in_range_p2_q;
  logic        blank_n_p2_q;
  logic        hs_p2_q;
  logic        vs_p2_q;

  // combinational next-state
  logic [6:0]  col_d;
  logic [4:0]  row_d;
  logic [11:0] idx_d;
  logic        in_range_d;
  logic [9:0]  vram_addr_d;
  logic [6:0]  code_d;
  logic        inv_d;
  logic [10:0] font_addr_d;
  logic        pix_d;
  logic [11:0] rgb_d;
  logic        vs_fall_d;
  logic        cursor_flip_d;

  // ---------------------------------------------------------------------------
  // Stage 1: screen position -> VRAM word address
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d       = draw_x[9:3];
    row_d       = draw_y[8:4];
    // row*COLS stays inside 12 bits as long as COLS*ROWS <= 4096
    idx_d       = 12'(row_d) * 12'(COLS) + 12'(col_d);
    in_range_d  = (int'(col_d) < COLS) && (int'(row_d) < ROWS) && blank_n;
    // parking the address at 0 outside the text area keeps the VRAM read
    // inside the populated words
    vram_addr_d = in_range_d ? idx_d[11:2] : 10'd0;
  end

  always_ff @(posedge CLK) begin
    if (pixel_en) begin
      byte_sel_p1_q <= idx_d[1:0];
      scan_p1_q     <= draw_y[3:0];
      xbit_p1_q     <= draw_x[2:0];
      in_range_p1_q <= in_range_d;
      blank_n_p1_q  <= blank_n;
      hs_p1_q       <= hs_in;
      vs_p1_q       <= vs_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: VRAM word -> character code -> font ROM address
  // ---------------------------------------------------------------------------
  always_comb begin
    code_d      = vram_rdata[{byte_sel_p1_q, 3'b000} +: 7];
    inv_d       = vram_rdata[{byte_sel_p1_q, 3'b111}];
    font_addr_d = {code_d, scan_p1_q};
  end

  always_ff @(posedge CLK) begin
    if (pixel_en) begin
      inv_p2_q      <= inv_d;
      xbit_p2_q     <= xbit_p1_q;
      in_range_p2_q <= in_range_p1_q;
      blank_n_p2_q  <= blank_n_p1_q;
      hs_p2_q       <= hs_p1_q;
      vs_p2_q       <= vs_p1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: glyph row -> pixel -> registered colour
  // ---------------------------------------------------------------------------
  always_comb begin
    pix_d = font_data[3'd7 - xbit_p2_q] ^ inv_p2_q ^ cursor_flip_d;
    // colours come straight from ctrl_reg here, so a colour write is seen by
    // the very next pixel leaving the pipe
    rgb_d = pick_rgb(blank_n_p2_q, in_range_p2_q, pix_d,
                     ctrl_reg[24:13], ctrl_reg[12:1]);
  end

  assign vs_fall_d = vs_prev_q & ~vs_in;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vram_addr_q    <= 10'd0;
      font_addr_q    <= 11'd0;
      rgb_q          <= 12'h000;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      frame_toggle_q <= 1'b0;
      vs_prev_q      <= 1'b1;
      vld_p1_q       <= 1'b0;
      vld_p2_q       <= 1'b0;
    end else if (pixel_en) begin
      vram_addr_q <= vram_addr_d;
      vld_p1_q    <= 1'b1;
      vld_p2_q    <= vld_p1_q;
      // the valid bits keep uninitialised datapath contents away from the
      // outputs for the first two ticks after reset
      if (vld_p1_q) begin
        font_addr_q <= font_addr_d;
      end
      if (vld_p2_q) begin
        rgb_q <= rgb_d;
        hs_q  <= hs_p2_q;
        vs_q  <= vs_p2_q;
      end
      vs_prev_q <= vs_in;
      if (vs_fall_d) begin
        frame_toggle_q <= ~frame_toggle_q;
      end
    end
  end

`ifdef VGA_TEXT_CURSOR_EN
  // ---------------------------------------------------------------------------
  // Cursor blink: frame counter and blink phase
  // ---------------------------------------------------------------------------
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_q;
  logic            blink_on_q;
  logic            cur_hit_d;
  logic            cur_hit_p1_q;
  logic            cur_hit_p2_q;

  // underline occupies the two bottom scanlines of the cursor cell
  assign cur_hit_d = (idx_d == cursor_pos) && (draw_y[3:0] >= 4'd14);

  always_ff @(posedge CLK) begin
    if (pixel_en) begin
      cur_hit_p1_q <= cur_hit_d;
      cur_hit_p2_q <= cur_hit_p1_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (pixel_en && vs_fall_d) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // XOR after the inverse attribute, so the underline shows on inverse glyphs
  assign cursor_flip_d = blink_on_q & cur_hit_p2_q;

  logic unused_in;
  assign unused_in = ^{draw_y[9], ctrl_reg[31:25], ctrl_reg[0]};
`else
  // no cursor: behaves as a cursor build whose blink phase is permanently off
  assign cursor_flip_d = 1'b0;

  logic unused_in;
  assign unused_in = ^{draw_y[9], ctrl_reg[31:25], ctrl_reg[0], cursor_pos,
                       (BLINK_FRAMES != 0)};
`endif

  assign vram_addr         = vram_addr_q;
  assign font_addr         = font_addr_q;
  assign {red, green, blue} = rgb_q;
  assign hs                = hs_q;
  assign vs                = vs_q;
  assign frame_toggle      = frame_toggle_q;

endmodule
